// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters for fetch-stage
// prediction, EX-stage resolution that drives the fetch redirect, and
// branch/mispredict statistics.
module branch_predict_unit #(
   parameter int         DEPTH    = 16,
   parameter logic [1:0] CNT_INIT = 2'b10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [2:0]  ex_branch,
   input  logic        ex_zero,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic [1:0]  pc_src,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] br_count,
   output logic [31:0] mispredict_count
);

   localparam int IDX   = $clog2(DEPTH);
   localparam int TAG_W = 30 - IDX;

   localparam logic [2:0] BR_BEQ = 3'b001;
   localparam logic [2:0] BR_J   = 3'b010;
   localparam logic [2:0] BR_JR  = 3'b011;
   localparam logic [2:0] BR_BNE = 3'b100;

   localparam logic [1:0] SRC_SEQ    = 2'b00;
   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_JUMP   = 2'b10;
   localparam logic [1:0] SRC_JR     = 2'b11;

   logic             valid_q  [DEPTH];
   logic             valid_d  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [TAG_W-1:0] tag_d    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [31:0]      target_d [DEPTH];
   logic [1:0]       cnt_q    [DEPTH];
   logic [1:0]       cnt_d    [DEPTH];

   logic [31:0] br_count_q;
   logic [31:0] br_count_d;
   logic [31:0] mispredict_count_q;
   logic [31:0] mispredict_count_d;

   logic [IDX-1:0]   if_idx;
   logic [TAG_W-1:0] if_tag;
   logic [IDX-1:0]   ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;

   logic is_beq;
   logic is_bne;
   logic is_j;
   logic is_jr;
   logic is_cond;
   logic actual_taken;

   logic if_pc_unused;

   assign if_idx       = if_pc[IDX+1:2];
   assign if_tag       = if_pc[31:IDX+2];
   assign ex_idx       = ex_pc[IDX+1:2];
   assign ex_tag       = ex_pc[31:IDX+2];
   assign if_pc_unused = ^if_pc[1:0];

   // Fetch-stage lookup: predict taken only on a valid tag hit with a taken-leaning counter.
   always_comb begin
      pred_taken  = 1'b0;
      pred_target = '0;
      if (valid_q[if_idx] && (tag_q[if_idx] == if_tag) && cnt_q[if_idx][1]) begin
         pred_taken  = 1'b1;
         pred_target = target_q[if_idx];
      end
   end

   // EX-stage decode: classify the instruction and work out whether it really redirects.
   always_comb begin
      is_beq       = ex_valid && (ex_branch == BR_BEQ);
      is_bne       = ex_valid && (ex_branch == BR_BNE);
      is_j         = ex_valid && (ex_branch == BR_J);
      is_jr        = ex_valid && (ex_branch == BR_JR);
      is_cond      = is_beq || is_bne;
      actual_taken = (is_beq && ex_zero) || (is_bne && !ex_zero) || is_j || is_jr;
   end

   // Resolution: compare the carried prediction with the real outcome and steer fetch.
   always_comb begin
      flush       = 1'b0;
      pc_src      = SRC_SEQ;
      redirect_pc = '0;
      if (is_cond) begin
         redirect_pc = actual_taken ? ex_target : (ex_pc + 32'd4);
         pc_src      = actual_taken ? SRC_BRANCH : SRC_SEQ;
         flush       = (actual_taken != ex_pred_taken) ||
                       (actual_taken && ex_pred_taken && (ex_pred_target != ex_target));
      end else if (is_j) begin
         flush       = 1'b1;
         pc_src      = SRC_JUMP;
         redirect_pc = ex_target;
      end else if (is_jr) begin
         flush       = 1'b1;
         pc_src      = SRC_JR;
         redirect_pc = ex_target;
      end
   end

   // Table next-state: train the counter on a hit, allocate on a taken miss, otherwise hold.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      if (is_cond) begin
         if (ex_hit) begin
            if (actual_taken) begin
               target_d[ex_idx] = ex_target;
               if (cnt_q[ex_idx] != 2'b11) begin
                  cnt_d[ex_idx] = cnt_q[ex_idx] + 2'b01;
               end
            end else if (cnt_q[ex_idx] != 2'b00) begin
               cnt_d[ex_idx] = cnt_q[ex_idx] - 2'b01;
            end
         end else if (actual_taken) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = ex_target;
            cnt_d[ex_idx]    = CNT_INIT;
         end
      end
   end

   // Statistics next-state: both counters wrap naturally at 32 bits.
   always_comb begin
      br_count_d         = br_count_q + {31'd0, (is_cond || is_j || is_jr)};
      mispredict_count_d = mispredict_count_q + {31'd0, flush};
   end

   // State registers with synchronous reset taking priority over any update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         br_count_q         <= '0;
         mispredict_count_q <= '0;
      end else begin
         valid_q            <= valid_d;
         tag_q              <= tag_d;
         target_q           <= target_d;
         cnt_q              <= cnt_d;
         br_count_q         <= br_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign br_count         = br_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed vectors plus a short pseudo-random
// burst, checked every cycle against a behavioural table model.
module tb_branch_predict_unit;

   localparam int DEPTH = 16;
   localparam int IDX   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [2:0]  ex_branch;
   logic        ex_zero;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [1:0]  pc_src;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] mispredict_count;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Behavioural model state: one entry per index, remembering the full branch PC.
   bit          m_valid [DEPTH];
   logic [31:0] m_pc    [DEPTH];
   logic [31:0] m_tgt   [DEPTH];
   int          m_cnt   [DEPTH];
   logic [31:0] m_br;
   logic [31:0] m_mis;

   branch_predict_unit #(.DEPTH(DEPTH), .CNT_INIT(2'b10)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_zero          (ex_zero),
      .ex_pc            (ex_pc),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .pc_src           (pc_src),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .br_count         (br_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   function automatic int slotOf(input logic [31:0] pc);
      return int'(pc >> 2) % DEPTH;
   endfunction

   function automatic bit sameBlock(input logic [31:0] a, input logic [31:0] b);
      return (a >> (IDX + 2)) == (b >> (IDX + 2));
   endfunction

   function automatic bit modelPredTaken(input logic [31:0] pc);
      int s = slotOf(pc);
      return m_valid[s] && sameBlock(m_pc[s], pc) && (m_cnt[s] >= 2);
   endfunction

   function automatic logic [31:0] modelPredTarget(input logic [31:0] pc);
      return modelPredTaken(pc) ? m_tgt[slotOf(pc)] : 32'd0;
   endfunction

   function automatic bit isCond();
      return ex_valid && (ex_branch == 3'd1 || ex_branch == 3'd4);
   endfunction

   function automatic bit isJump();
      return ex_valid && (ex_branch == 3'd2 || ex_branch == 3'd3);
   endfunction

   function automatic bit modelTaken();
      if (!ex_valid) return 1'b0;
      case (ex_branch)
         3'd1:    return ex_zero;
         3'd4:    return !ex_zero;
         3'd2:    return 1'b1;
         3'd3:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected EX-stage outputs from the resolution rules
   task automatic modelEx(output logic f, output logic [1:0] s, output logic [31:0] r);
      bit t = modelTaken();
      f = 1'b0;
      s = 2'd0;
      r = 32'd0;
      if (isCond()) begin
         if (ex_pred_taken) f = !t || (ex_pred_target != ex_target);
         else               f = t;
         s = t ? 2'd1 : 2'd0;
         r = t ? ex_target : ex_pc + 32'd4;
      end else if (isJump()) begin
         f = 1'b1;
         s = (ex_branch == 3'd2) ? 2'd2 : 2'd3;
         r = ex_target;
      end
   endtask

   // Model update at each rising edge, reset first
   always @(posedge clk) begin
      logic        f;
      logic [1:0]  s;
      logic [31:0] r;
      int          k;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = 32'd0;
            m_tgt[i]   = 32'd0;
            m_cnt[i]   = 0;
         end
         m_br  = 32'd0;
         m_mis = 32'd0;
      end else begin
         modelEx(f, s, r);
         if (isCond() || isJump()) m_br = m_br + 32'd1;
         if (f) m_mis = m_mis + 32'd1;
         if (isCond()) begin
            k = slotOf(ex_pc);
            if (m_valid[k] && sameBlock(m_pc[k], ex_pc)) begin
               if (modelTaken()) begin
                  m_cnt[k] = (m_cnt[k] < 3) ? m_cnt[k] + 1 : 3;
                  m_tgt[k] = ex_target;
               end else begin
                  m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
               end
            end else if (modelTaken()) begin
               m_valid[k] = 1'b1;
               m_pc[k]    = ex_pc;
               m_tgt[k]   = ex_target;
               m_cnt[k]   = 2;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      logic        f;
      logic [1:0]  s;
      logic [31:0] r;
      if (chk_en) begin
         modelEx(f, s, r);
         checkOutput("model.pred_taken", {31'd0, pred_taken}, {31'd0, modelPredTaken(if_pc)});
         checkOutput("model.pred_target", pred_target, modelPredTarget(if_pc));
         checkOutput("model.flush", {31'd0, flush}, {31'd0, f});
         checkOutput("model.pc_src", {30'd0, pc_src}, {30'd0, s});
         if (f) checkOutput("model.redirect_pc", redirect_pc, r);
         checkOutput("model.br_count", br_count, m_br);
         checkOutput("model.mispredict_count", mispredict_count, m_mis);
      end
   end

   task automatic applyStimulus(input logic r, input logic v, input logic [2:0] br,
                                input logic z, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic pt, input logic [31:0] ptgt, input logic [31:0] ipc);
      @(posedge clk);
      #1;
      rst            = r;
      ex_valid       = v;
      ex_branch      = br;
      ex_zero        = z;
      ex_pc          = pc;
      ex_target      = tgt;
      ex_pred_taken  = pt;
      ex_pred_target = ptgt;
      if_pc          = ipc;
   endtask

   task automatic idle(input logic [31:0] ipc);
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, ipc);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   logic [31:0] pcs [5];

   initial begin
      pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h44; pcs[3] = 32'h48; pcs[4] = 32'hC0;
      rst = 1'b1; ex_valid = 1'b0; ex_branch = 3'd0; ex_zero = 1'b0; ex_pc = 32'd0;
      ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0; if_pc = 32'h40;

      // Reset
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h40);
      idle(32'h40);
      settle();
      checkOutput("reset.pred_taken", {31'd0, pred_taken}, 32'd0);
      checkOutput("reset.pred_target", pred_target, 32'd0);
      checkOutput("reset.br_count", br_count, 32'd0);
      checkOutput("reset.mispredict_count", mispredict_count, 32'd0);

      // First taken beq allocates the entry
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      settle();
      checkOutput("alloc.flush", {31'd0, flush}, 32'd1);
      checkOutput("alloc.redirect_pc", redirect_pc, 32'h80);
      checkOutput("alloc.pc_src", {30'd0, pc_src}, 32'd1);
      idle(32'h40);
      settle();
      checkOutput("alloc.pred_taken", {31'd0, pred_taken}, 32'd1);
      checkOutput("alloc.pred_target", pred_target, 32'h80);

      // Train down twice, then up to saturation
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 32'h40, 32'h80, 1'b1, 32'h80, 32'h40);
      settle();
      checkOutput("nt1.flush", {31'd0, flush}, 32'd1);
      checkOutput("nt1.redirect_pc", redirect_pc, 32'h44);
      checkOutput("nt1.pc_src", {30'd0, pc_src}, 32'd0);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      settle();
      checkOutput("nt2.flush", {31'd0, flush}, 32'd0);
      idle(32'h40);
      settle();
      checkOutput("nt2.pred_taken", {31'd0, pred_taken}, 32'd0);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b1, 32'h80, 32'h40);
      settle();
      checkOutput("t3.flush", {31'd0, flush}, 32'd0);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b1, 32'h80, 32'h40);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b0, 32'h40, 32'h80, 1'b1, 32'h80, 32'h40);
      settle();
      checkOutput("sat.flush", {31'd0, flush}, 32'd1);
      idle(32'h40);
      settle();
      checkOutput("sat.pred_taken", {31'd0, pred_taken}, 32'd1);
      checkOutput("sat.mispredict_count", mispredict_count, 32'd5);
      checkOutput("sat.br_count", br_count, 32'd8);

      // Taken with a wrong predicted target
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b1, 32'h84, 32'h40);
      settle();
      checkOutput("badtgt.flush", {31'd0, flush}, 32'd1);
      checkOutput("badtgt.redirect_pc", redirect_pc, 32'h80);

      // Aliasing branch at 0x80 evicts 0x40
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h80, 32'h300, 1'b0, 32'd0, 32'h40);
      idle(32'h40);
      settle();
      checkOutput("evict.pred_taken_old", {31'd0, pred_taken}, 32'd0);
      idle(32'h80);
      settle();
      checkOutput("evict.pred_target_new", pred_target, 32'h300);

      // bne taken allocates, bne not-taken miss does not
      applyStimulus(1'b0, 1'b1, 3'd4, 1'b0, 32'h48, 32'h200, 1'b0, 32'd0, 32'h48);
      settle();
      checkOutput("bne.pc_src", {30'd0, pc_src}, 32'd1);
      applyStimulus(1'b0, 1'b1, 3'd4, 1'b1, 32'h4C, 32'h240, 1'b0, 32'd0, 32'h48);
      settle();
      checkOutput("bne_nt.flush", {31'd0, flush}, 32'd0);
      idle(32'h48);
      settle();
      checkOutput("bne.pred_target", pred_target, 32'h200);
      idle(32'h4C);
      settle();
      checkOutput("bne_nt.pred_taken", {31'd0, pred_taken}, 32'd0);

      // Jumps always flush; bubbles never do
      applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 32'h50, 32'h1000, 1'b0, 32'd0, 32'h50);
      settle();
      checkOutput("jr.flush", {31'd0, flush}, 32'd1);
      checkOutput("jr.pc_src", {30'd0, pc_src}, 32'd3);
      checkOutput("jr.redirect_pc", redirect_pc, 32'h1000);
      idle(32'h50);
      settle();
      checkOutput("jr.no_alloc", {31'd0, pred_taken}, 32'd0);
      applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 32'h54, 32'h2000, 1'b1, 32'h2000, 32'h54);
      settle();
      checkOutput("j_alias.flush", {31'd0, flush}, 32'd1);
      checkOutput("j.pc_src", {30'd0, pc_src}, 32'd2);
      applyStimulus(1'b0, 1'b0, 3'd1, 1'b1, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      settle();
      checkOutput("bubble.flush", {31'd0, flush}, 32'd0);
      checkOutput("bubble.pc_src", {30'd0, pc_src}, 32'd0);

      // Pseudo-random burst over a few aliasing PCs, checked by the model
      for (int n = 0; n < 80; n++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), pcs[$urandom_range(0, 4)],
                       pcs[$urandom_range(0, 4)] + 32'h100, 1'($urandom_range(0, 1)),
                       pcs[$urandom_range(0, 4)] + 32'h100, pcs[$urandom_range(0, 4)]);
      end

      // Reset wins over a same-cycle allocation
      applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 32'h44, 32'h400, 1'b0, 32'd0, 32'h44);
      settle();
      checkOutput("rst_alloc.flush", {31'd0, flush}, 32'd1);
      idle(32'h44);
      settle();
      checkOutput("rst_alloc.pred_taken", {31'd0, pred_taken}, 32'd0);
      checkOutput("rst_alloc.br_count", br_count, 32'd0);

      // Mispredict counter wraps from all-ones to zero
      idle(32'h40);
      #2;
      force dut.mispredict_count_q = 32'hFFFF_FFFE;
      m_mis = 32'hFFFF_FFFE;
      #1;
      release dut.mispredict_count_q;
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      applyStimulus(1'b0, 1'b1, 3'd1, 1'b1, 32'h40, 32'h80, 1'b0, 32'd0, 32'h40);
      settle();
      checkOutput("wrap.pre", mispredict_count, 32'hFFFF_FFFF);
      idle(32'h40);
      settle();
      checkOutput("wrap.zero", mispredict_count, 32'd0);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
